// File: rtl/spi_seq_pkg.sv
// Shared types and widths for the SPI transaction sequencer.
package spi_seq_pkg;

  localparam int BYTE_W  = 8;
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/spi_txn_sequencer_sync_fifo.sv
// Synchronous first-word fall-through FIFO. Pop on an empty FIFO is ignored;
// push on a full FIFO is accepted only when a pop frees the slot that cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head is forced to zero when empty so the output has a defined reset value.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end

  // Storage array; contents need no reset since the head is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Byte-stream front end for the SPI master: TX FIFO -> one frame per byte ->
// RX FIFO. Tracks each frame through the master's chip select.
import spi_seq_pkg::*;

module spi_txn_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [BYTE_W-1:0] spi_din,
  output logic              spi_newd,
  input  logic              spi_cs,
  input  logic [BYTE_W-1:0] spi_dout,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int CW = $clog2(DEPTH) + 1;

  seq_state_t         state;
  logic               cs_q, cs_fall, cs_rise;
  logic [TIMER_W-1:0] timer;
  logic [BYTE_W-1:0]  shadow;

  logic [BYTE_W-1:0]  tx_head;
  logic               tx_full, tx_empty, tx_pop, tx_push;
  logic               rx_full, rx_empty, rx_push;
  logic [CW-1:0]      tx_count, rx_count;
  logic               launch, timer_hit, timeout_hit;
  logic               unused_cnt;

  assign cs_fall   = cs_q & ~spi_cs;
  assign cs_rise   = ~cs_q & spi_cs;
  assign timer_hit = (timer == TIMER_W'(TIMEOUT));

  // One frame in flight at most, and its RX slot is reserved before launch.
  assign launch = (state == IDLE) && !tx_empty && !rx_full;

  // Edge completion wins over a timeout landing on the same cycle.
  assign timeout_hit = timer_hit &&
                       (((state == REQ)    && !cs_fall) ||
                        ((state == ACTIVE) && !cs_rise));

  // The byte leaves TX when the master accepts it, or is discarded if the
  // request times out. An ACTIVE abort has already popped its byte.
  assign tx_pop  = (state == REQ) && (cs_fall || timeout_hit);
  assign rx_push = (state == ACTIVE) && cs_rise;
  assign tx_push = tx_valid & tx_ready;

  assign tx_ready   = ~tx_full;
  assign rx_valid   = ~rx_empty;
  assign busy       = (state != IDLE);
  assign unused_cnt = ^{tx_count, rx_count};

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (tx_data),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (shadow),
    .pop   (rx_ready),
    .rdata (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // cs edge detector; idles high so a frame already low at reset is not
  // mistaken for a fresh launch (IDLE ignores edges anyway).
  always_ff @(posedge clk) begin
    if (rst) cs_q <= 1'b1;
    else     cs_q <= spi_cs;
  end

  // Sticky error flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)              timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
    else if (err_clr)     timeout_err <= 1'b0;
  end

  // Shadow tracks dout while the frame is live; the master clears dout on
  // the edge cs rises, so the value held here is the received byte.
  always_ff @(posedge clk) begin
    if (rst)                              shadow <= '0;
    else if (state == ACTIVE && !spi_cs)  shadow <= spi_dout;
  end

  // Sequencer FSM with saturating watchdog timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      spi_din  <= '0;
      spi_newd <= 1'b0;
      timer    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state    <= REQ;
            spi_din  <= tx_head;
            spi_newd <= 1'b1;
            timer    <= '0;
          end
        end
        REQ: begin
          // newd stays up until the master's slow sclk edge picks it up.
          if (cs_fall) begin
            state    <= ACTIVE;
            spi_newd <= 1'b0;
            timer    <= '0;
          end else if (timeout_hit) begin
            state    <= IDLE;
            spi_newd <= 1'b0;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise || timeout_hit) begin
            state    <= IDLE;
            spi_newd <= 1'b0;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          spi_newd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench: two sequencers (DEPTH 8 and DEPTH 2), each driving a small
// behavioural SPI master with sdo looped back to sdi.
module tb_spi_txn_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   last_wait = 0;

  logic [7:0] tx_data0 = '0, tx_data1 = '0;
  logic       tx_valid0 = 1'b0, tx_valid1 = 1'b0;
  logic       rx_ready0 = 1'b0, rx_ready1 = 1'b0;
  logic       err_clr0 = 1'b0, err_clr1 = 1'b0;
  logic       cs_force0 = 1'b0;
  logic       tx_ready0, tx_ready1, rx_valid0, rx_valid1;
  logic       newd0, newd1, busy0, busy1, terr0, terr1;
  logic [7:0] rx_data0, rx_data1, din0, din1;
  logic       cs0, cs1;
  logic [7:0] dout0, dout1;

  // behavioural master state, one slot per DUT
  logic       m_cs   [2];
  logic       m_act  [2];
  logic [7:0] m_dout [2];
  logic [7:0] m_sr   [2];
  logic [1:0] m_div  [2];
  logic [3:0] m_cnt  [2];

  logic [7:0] q0[$], q1[$];
  int         frames0 = 0, frames1 = 0;
  logic       csp0 = 1'b1, csp1 = 1'b1;
  logic       ready_bad = 1'b0;

  always #5 clk = ~clk;

  assign cs0   = m_cs[0] | cs_force0;
  assign cs1   = m_cs[1];
  assign dout0 = m_dout[0];
  assign dout1 = m_dout[1];

  spi_txn_sequencer #(.DEPTH(8), .TIMEOUT(255)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_ready(rx_ready0), .spi_din(din0), .spi_newd(newd0), .spi_cs(cs0),
    .spi_dout(dout0), .busy(busy0), .timeout_err(terr0), .err_clr(err_clr0)
  );

  spi_txn_sequencer #(.DEPTH(2), .TIMEOUT(255)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_ready(rx_ready1), .spi_din(din1), .spi_newd(newd1), .spi_cs(cs1),
    .spi_dout(dout1), .busy(busy1), .timeout_err(terr1), .err_clr(err_clr1)
  );

  // Master model: sclk tick every 4 clk; newd sampled only on a tick; dout
  // builds the looped-back byte and is zeroed on the tick cs rises.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (m_rst) begin
        m_cs[g] <= 1'b1; m_act[g] <= 1'b0; m_dout[g] <= '0;
        m_sr[g] <= '0;   m_div[g] <= '0;   m_cnt[g]  <= '0;
      end else begin
        m_div[g] <= m_div[g] + 2'd1;
        if (m_div[g] == 2'd3) begin
          if (!m_act[g]) begin
            if ((g == 0) ? newd0 : newd1) begin
              m_act[g] <= 1'b1; m_cs[g] <= 1'b0; m_dout[g] <= '0; m_cnt[g] <= '0;
              m_sr[g]  <= (g == 0) ? din0 : din1;
            end
          end else if (m_cnt[g] < 4'd8) begin
            m_dout[g] <= {m_dout[g][6:0], m_sr[g][7]};
            m_sr[g]   <= {m_sr[g][6:0], 1'b0};
            m_cnt[g]  <= m_cnt[g] + 4'd1;
          end else begin
            m_cs[g] <= 1'b1; m_dout[g] <= '0; m_act[g] <= 1'b0;
          end
        end
      end
    end
  end

  // Monitors sampled mid-cycle: host pops, cs frames, tx_ready while full.
  always @(negedge clk) begin
    if (rx_valid0 && rx_ready0) q0.push_back(rx_data0);
    if (rx_valid1 && rx_ready1) q1.push_back(rx_data1);
    if (csp0 && !cs0) frames0 <= frames0 + 1;
    if (csp1 && !cs1) frames1 <= frames1 + 1;
    csp0 <= cs0;
    csp1 <= cs1;
    if (u_dut1.u_tx.count == 2'd2 && tx_ready1) ready_bad <= 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qat(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 8'hxx;
  endfunction

  // Hold valid until tx_ready is seen, then complete the handshake edge.
  task automatic push(input int g, input logic [7:0] d);
    int n = 0;
    if (g == 0) begin tx_data0 = d; tx_valid0 = 1'b1; end
    else        begin tx_data1 = d; tx_valid1 = 1'b1; end
    while (((g == 0) ? tx_ready0 : tx_ready1) !== 1'b1 && n < 1000) begin
      step(1);
      n++;
    end
    last_wait = n;
    chk("push_accept", 32'(n < 1000), 32'd1);
    step(1);
    if (g == 0) tx_valid0 = 1'b0; else tx_valid1 = 1'b0;
  endtask

  task automatic wait_rx(input int g, input int size, input string tag);
    int n = 0;
    while (((g == 0) ? q0.size() : q1.size()) < size && n < 2000) begin
      step(1);
      n++;
    end
    chk(tag, (g == 0) ? q0.size() : q1.size(), size);
  endtask

  initial begin
    int  n;
    logic dropped;

    // reset state
    step(3);
    m_rst = 1'b0;
    chk("rst_tx_ready", tx_ready0, 1);
    chk("rst_rx_valid", rx_valid0, 0);
    chk("rst_rx_data",  rx_data0,  0);
    chk("rst_busy",     busy0,     0);
    chk("rst_newd",     newd0,     0);
    chk("rst_din",      din0,      0);
    chk("rst_terr",     terr0,     0);
    rst = 1'b0;
    step(2);

    // 1: single byte, newd held until cs falls, one frame
    rx_ready0 = 1'b1;
    push(0, 8'hA5);
    n = 0;
    while (!newd0 && n < 10) begin step(1); n++; end
    chk("t1_newd_up", newd0, 1);
    dropped = 1'b0;
    n = 0;
    while (cs0 && n < 100) begin
      if (!newd0) dropped = 1'b1;
      step(1);
      n++;
    end
    chk("t1_cs_low",     cs0,     0);
    chk("t1_newd_held",  dropped, 0);
    wait_rx(0, 1, "t1_rx_count");
    chk("t1_rx_data",    qat(q0, 0), 8'hA5);
    step(5);
    chk("t1_busy_idle",  busy0,    0);
    chk("t1_rx_empty",   rx_valid0, 0);
    chk("t1_frames",     frames0,  1);

    // 2: back-to-back burst, order preserved, no backpressure
    push(0, 8'h01); chk("t2_ready", last_wait, 0);
    push(0, 8'h80); chk("t2_ready", last_wait, 0);
    push(0, 8'hFF); chk("t2_ready", last_wait, 0);
    push(0, 8'h3C); chk("t2_ready", last_wait, 0);
    wait_rx(0, 5, "t2_rx_count");
    chk("t2_b0", qat(q0, 1), 8'h01);
    chk("t2_b1", qat(q0, 2), 8'h80);
    chk("t2_b2", qat(q0, 3), 8'hFF);
    chk("t2_b3", qat(q0, 4), 8'h3C);
    step(5);
    chk("t2_frames", frames0, 5);

    // 6: zero byte is real data
    push(0, 8'h00);
    wait_rx(0, 6, "t6_rx_count");
    chk("t6_zero", qat(q0, 5), 8'h00);
    step(5);

    // 4: timeout with cs stuck high; 256 clks in REQ before abort
    cs_force0 = 1'b1;
    push(0, 8'h55);
    step(256);
    chk("t4_no_err_yet", terr0, 0);
    chk("t4_busy_req",   busy0, 1);
    chk("t4_newd_req",   newd0, 1);
    step(1);
    chk("t4_err_set",    terr0, 1);
    chk("t4_busy_idle",  busy0, 0);
    chk("t4_newd_low",   newd0, 0);
    chk("t4_tx_empty",   u_dut0.u_tx.count, 0);
    chk("t4_no_rx",      q0.size(), 6);
    chk("t4_rx_valid",   rx_valid0, 0);
    err_clr0 = 1'b1;
    step(1);
    err_clr0 = 1'b0;
    chk("t4_err_clr",    terr0, 0);
    step(80);
    cs_force0 = 1'b0;
    step(10);

    // 5: reset in the middle of a frame
    push(0, 8'h77);
    n = 0;
    while (cs0 && n < 100) begin step(1); n++; end
    chk("t5_cs_low", cs0, 0);
    step(8);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_newd",     newd0,     0);
    chk("t5_rx_valid", rx_valid0, 0);
    chk("t5_busy",     busy0,     0);
    n = 0;
    while (!cs0 && n < 100) begin step(1); n++; end
    chk("t5_cs_high", cs0, 1);
    step(5);
    chk("t5_no_rx",    q0.size(), 6);
    chk("t5_busy_ign", busy0, 0);
    push(0, 8'h5A);
    wait_rx(0, 7, "t5_rx_count");
    chk("t5_data", qat(q0, 6), 8'h5A);

    // 3: DEPTH=2 backpressure from RX
    push(1, 8'h11);
    push(1, 8'h22);
    push(1, 8'h33);
    push(1, 8'h44);
    step(300);
    chk("t3_frames_hold", frames1, 2);
    chk("t3_busy",        busy1, 0);
    chk("t3_newd",        newd1, 0);
    chk("t3_tx_count",    u_dut1.u_tx.count, 2);
    chk("t3_tx_ready",    tx_ready1, 0);
    chk("t3_rx_valid",    rx_valid1, 1);
    chk("t3_rx_head",     rx_data1, 8'h11);
    rx_ready1 = 1'b1;
    wait_rx(1, 4, "t3_rx_count");
    chk("t3_b0", qat(q1, 0), 8'h11);
    chk("t3_b1", qat(q1, 1), 8'h22);
    chk("t3_b2", qat(q1, 2), 8'h33);
    chk("t3_b3", qat(q1, 3), 8'h44);
    step(5);
    chk("t3_frames",    frames1, 4);
    chk("t3_ready_full", ready_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
